sender_buf: RTL
===============

SENDER_BUF -- requirements
Module: sender_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning buffer words; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter OLDEST_FIRST, default 0: 0 = send from address 0 upward; 1 = send starting at write pointer (oldest word first).
REQ-004 Port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port write, input, 1 bit: store data at write pointer this cycle.
REQ-007 Port data, input, DATA_W bits: word to store.
REQ-008 Port start, input, 1 bit: begin a transfer.
REQ-009 Port len, input, clog2(DEPTH)+1 bits: words to send, sampled with start; 0 or >DEPTH means DEPTH.
REQ-010 Port Ack, input, 1 bit: receiver acknowledge.
REQ-011 Port Request, output, 1 bit: sdrDataOut valid, awaiting Ack.
REQ-012 Port sdrDataOut, output, DATA_W bits: word being offered.
REQ-013 Port busy, output, 1 bit: transfer in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse after the last word completes.
REQ-015 Port wr_drop, output, 1 bit: one-cycle pulse when a write is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, REL.
REQ-017 IDLE: on start=1, latch len (applying REQ-009) into a remaining counter, set read pointer to 0 (OLDEST_FIRST=0) or to the write pointer (OLDEST_FIRST=1), go to REQ next cycle.
REQ-018 REQ: Request=1, sdrDataOut=mem[read pointer]; on Ack=1, drop Request next cycle, increment read pointer modulo DEPTH, decrement remaining, go to REL.
REQ-019 REL: Request=0; stay until Ack=0; then go to REQ if remaining>0, else assert done for one cycle and go to IDLE.
REQ-020 Handshake is four-phase: Request SHALL NOT re-assert while Ack is still high; an Ack held high across words SHALL NOT accept more than one word.
REQ-021 Ack=1 while in IDLE SHALL be ignored and SHALL NOT start a transfer.
REQ-022 First Request SHALL appear exactly one cycle after start is sampled.
REQ-023 In IDLE, write=1 SHALL store data at write pointer and increment it modulo DEPTH; the DEPTH+1-th write overwrites address 0.
REQ-024 While busy, write=1 SHALL NOT modify memory or write pointer and SHALL pulse wr_drop next cycle.
REQ-025 start while busy SHALL be ignored.
REQ-026 write and start in the same IDLE cycle: the write SHALL complete and the transfer SHALL start; with OLDEST_FIRST=1, the start pointer SHALL be the incremented write pointer.
REQ-027 busy SHALL be 1 exactly when state is REQ or REL.
REQ-028 sdrDataOut SHALL be registered and SHALL hold its value while Request=1.

Reset
REQ-029 Reset=1 SHALL immediately force IDLE, Request=0, busy=0, done=0, wr_drop=0, sdrDataOut=0, write and read pointers=0, remaining=0.
REQ-030 Reset SHALL initialise mem[i]=i (zero-extended to DATA_W) for every i.
REQ-031 Reset mid-transfer SHALL abort the transfer without a done pulse; after release the block SHALL be in IDLE.

Structure
REQ-032 Package sender_pkg SHALL hold the FSM state typedef and the default DATA_W/DEPTH constants.
REQ-033 Storage SHALL be a sub-module sender_mem (register array, one write port, one async read port, reset initialisation per REQ-030).

Verification
REQ-034 Reset, start with len=0, ack each Request for one cycle -> 16 words 0x0000..0x000F in order, then done pulse, busy=0.
REQ-035 Writes 0x1000..0x1011 (18 writes) in IDLE, then start, len=0 -> 0x1010, 0x1011, 0x1002..0x100F (OLDEST_FIRST=0); with OLDEST_FIRST=1 -> 0x1002..0x1011.
REQ-036 start with len=3, Ack held high for 4 cycles per word -> exactly 3 words, one word per Ack high period, done after the third.
REQ-037 write=1 during transfer -> wr_drop pulse, memory unchanged (resend shows identical data).
REQ-038 Reset asserted while Request=1 -> Request=0 at once, no done pulse; next start resends from reset-initialised memory.
REQ-039 DATA_W=8, DEPTH=4 build -> len=0 sends 4 words, write pointer wraps after 4 writes.

Source files
------------

// File: rtl/sender_pkg.sv
// -----------------------------------------------------------------------------
// sender_pkg
//   Shared definitions for the sender buffer slice:
//     - default word width and buffer depth
//     - FSM state type and encodings (IDLE / REQ / REL)
//     - eff_len(): maps a requested transfer length onto the number of words
//       actually sent (0 or anything above the depth means "whole buffer")
// -----------------------------------------------------------------------------
package sender_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // FSM state encoding; kept as plain constants so older code that compares
    // against raw 2-bit values keeps working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_REL  = 2'd2;

    // Number of words a transfer will send for a given requested length.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned depth);
        if ((len == 32'd0) || (len > depth)) begin
            return depth;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/sender_mem.sv
// -----------------------------------------------------------------------------
// sender_mem
//   Register-array word store for the sender buffer. One synchronous write
//   port, one asynchronous read port. Reset loads every word with its own
//   address (zero-extended / truncated to DATA_W) so a freshly reset buffer
//   sends a recognisable ramp.
//
//   Ports
//     clk    : rising-edge clock
//     rst    : asynchronous, active-high reset (loads the address ramp)
//     we     : write enable
//     waddr  : write address
//     wdata  : write data
//     raddr  : read address
//     rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sender_mem #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Word storage: ramp initialisation on reset, single write port otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(i);
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sender_buf.sv
// -----------------------------------------------------------------------------
// sender_buf
//   Small transmit buffer. Words are written into a circular store while the
//   block is idle; a start request then plays out a number of words to a
//   receiver over a four-phase Request/Ack handshake.
//
//   Parameters
//     DATA_W       : word width in bits
//     DEPTH        : number of buffered words (power of two, >= 2)
//     OLDEST_FIRST : 0 = play out from address 0 upward,
//                    1 = play out from the write pointer (oldest word first)
//
//   Ports
//     clk        : rising-edge clock
//     Reset      : asynchronous, active-high reset
//     write      : store data at the write pointer (idle only)
//     data       : word to store
//     start      : begin a transfer (idle only)
//     len        : words to send, sampled with start (0 or >DEPTH = DEPTH)
//     Ack        : receiver acknowledge
//     Request    : sdrDataOut is valid and awaiting Ack
//     sdrDataOut : word being offered (registered, stable while Request=1)
//     busy       : transfer in progress (state REQ or REL)
//     done       : one-cycle pulse after the last word's handshake completes
//     wr_drop    : one-cycle pulse when a write arrives while busy
// -----------------------------------------------------------------------------
module sender_buf
    import sender_pkg::*;
#(
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int DEPTH        = DEF_DEPTH,
    parameter  int OLDEST_FIRST = 0,
    localparam int AW           = $clog2(DEPTH),
    localparam int LW           = AW + 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              write,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    input  logic [LW-1:0]     len,
    input  logic              Ack,
    output logic              Request,
    output logic [DATA_W-1:0] sdrDataOut,
    output logic              busy,
    output logic              done,
    output logic              wr_drop
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     wptr_r;
    logic [AW-1:0]     rptr_r;
    logic [LW-1:0]     rem_r;
    logic              request_r;
    logic [DATA_W-1:0] dout_r;
    logic              busy_r;
    logic              done_r;
    logic              wr_drop_r;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic              idle_s;
    logic              mem_we_s;
    logic [AW-1:0]     wptr_inc_s;
    logic [AW-1:0]     start_ptr_s;
    logic [AW-1:0]     raddr_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] first_word_s;
    logic [LW-1:0]     len_eff_s;

    assign idle_s     = (state_r == ST_IDLE);
    // Writes are only honoured while idle; while busy they are dropped.
    assign mem_we_s   = idle_s && write;
    assign wptr_inc_s = wptr_r + AW'(1);
    assign len_eff_s  = LW'(eff_len(32'(len), 32'(DEPTH)));

    // Start address of a new transfer. In oldest-first mode a write in the
    // same cycle as start has already advanced the pointer, so the oldest
    // word sits one past the address being written.
    always_comb begin
        start_ptr_s = {AW{1'b0}};
        if (OLDEST_FIRST != 0) begin
            if (write) begin
                start_ptr_s = wptr_inc_s;
            end else begin
                start_ptr_s = wptr_r;
            end
        end else begin
            start_ptr_s = {AW{1'b0}};
        end
    end

    // While idle the read port looks at the address the next transfer will
    // open with, so the first word can be registered in the start cycle.
    always_comb begin
        raddr_s = rptr_r;
        if (idle_s) begin
            raddr_s = start_ptr_s;
        end else begin
            raddr_s = rptr_r;
        end
    end

    // First-word bypass: a write and start in the same cycle may target the
    // very address being read (address 0 in from-zero mode); the memory does
    // not hold the new word yet, so take it straight from the data input.
    always_comb begin
        first_word_s = rdata_s;
        if (mem_we_s && (wptr_r == raddr_s)) begin
            first_word_s = data;
        end else begin
            first_word_s = rdata_s;
        end
    end

    sender_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (Reset),
        .we    (mem_we_s),
        .waddr (wptr_r),
        .wdata (data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Next-state logic for the four-phase handshake FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (Ack) begin
                    state_nxt_s = ST_REL;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REL: begin
                // Ack must fall before the next word is offered, so a held
                // Ack can never accept more than one word.
                if (Ack) begin
                    state_nxt_s = ST_REL;
                end else if (rem_r != {LW{1'b0}}) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and status flags (busy, done, wr_drop), all registered.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_drop_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_r == ST_REL) && (state_nxt_s == ST_IDLE);
            wr_drop_r <= write && !idle_s;
        end
    end

    // Write pointer: advances with every accepted write, wrapping at DEPTH.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wptr_r <= {AW{1'b0}};
        end else if (mem_we_s) begin
            wptr_r <= wptr_inc_s;
        end
    end

    // Transfer datapath: read pointer, remaining count, Request and the
    // registered output word.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rptr_r    <= {AW{1'b0}};
            rem_r     <= {LW{1'b0}};
            request_r <= 1'b0;
            dout_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rem_r     <= len_eff_s;
                        rptr_r    <= start_ptr_s;
                        request_r <= 1'b1;
                        dout_r    <= first_word_s;
                    end
                end
                ST_REQ: begin
                    if (Ack) begin
                        request_r <= 1'b0;
                        rptr_r    <= rptr_r + AW'(1);
                        rem_r     <= rem_r - LW'(1);
                    end
                end
                ST_REL: begin
                    // No writes happen while busy, so the plain memory read
                    // is current here.
                    if (!Ack && (rem_r != {LW{1'b0}})) begin
                        request_r <= 1'b1;
                        dout_r    <= rdata_s;
                    end
                end
                default: begin
                    request_r <= 1'b0;
                end
            endcase
        end
    end

    assign Request    = request_r;
    assign sdrDataOut = dout_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign wr_drop    = wr_drop_r;

endmodule
